// File: rtl/pci_arbiter_n.sv
// rtl/pci_arbiter_n.sv - parametrised PCI central bus arbiter
//
// Grants the shared Frame/Irdy bus to one of NUM_MASTERS initiators.
// Arbitration is fixed priority (index 0 highest) or round robin, chosen
// by Mode at each arbitration edge. A master that is granted but does not
// start a transaction within GNT_TIMEOUT cycles loses the grant.
//
// Optional build macro: ARB_PARK_EN (park the idle grant on PARK_MASTER).
//
// Ports:
//   Clk          bus clock, rising edge
//   Rst_n        asynchronous active-low reset
//   REQ_n        per-master request, active low
//   Frame, Irdy  PCI FRAME# / IRDY#, active low
//   Mode         0 = fixed priority, 1 = round robin
//   GNT_n        per-master grant, active low, registered, one-hot-low
//   Owner        index of the current or last granted master
//   Owner_valid  high while a requested grant or transaction is in progress
//   Timeout      one-cycle pulse when a grant is withdrawn by timeout

module pci_arbiter_n #(
  parameter int NUM_MASTERS = 3,
  parameter int GNT_TIMEOUT = 16,
  parameter int PARK_MASTER = 0,
  localparam int OW = (NUM_MASTERS > 2) ? $clog2(NUM_MASTERS) : 1
) (
  input  logic                   Clk,
  input  logic                   Rst_n,
  input  logic [NUM_MASTERS-1:0] REQ_n,
  input  logic                   Frame,
  input  logic                   Irdy,
  input  logic                   Mode,
  output logic [NUM_MASTERS-1:0] GNT_n,
  output logic [OW-1:0]          Owner,
  output logic                   Owner_valid,
  output logic                   Timeout
);

  if (NUM_MASTERS < 2 || NUM_MASTERS > 8 || GNT_TIMEOUT < 2 || GNT_TIMEOUT > 255 ||
      PARK_MASTER < 0 || PARK_MASTER >= NUM_MASTERS) begin : g_param_check
    $error("pci_arbiter_n: parameter out of range");
  end

  typedef enum logic [1:0] {S_IDLE, S_GRANTED, S_BUSY, S_TURN} state_t;

  state_t                 state_q, state_d;
  logic [NUM_MASTERS-1:0] gnt_q, gnt_d;
  logic [OW-1:0]          owner_q, owner_d;
  logic [OW-1:0]          last_q, last_d;
  logic                   valid_q, valid_d;
  logic                   timeout_q, timeout_d;
  logic [7:0]             cnt_q, cnt_d;

  logic [NUM_MASTERS-1:0] req;
  logic                   any_req;
  logic                   bus_idle;
  logic [OW-1:0]          win;

  assign req      = ~REQ_n;
  assign any_req  = |req;
  assign bus_idle = Frame && Irdy;

  // Winner search. Loops run from the lowest-priority candidate upward so
  // the last match written is the highest-priority requester.
  always_comb begin
    logic [OW-1:0] cur;
    win = '0;
    cur = '0;
    if (!Mode) begin
      for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
        cur = OW'(i);
        if (req[cur]) win = cur;
      end
    end else begin
      for (int k = NUM_MASTERS; k >= 1; k--) begin
        cur = OW'((int'(last_q) + k) % NUM_MASTERS);
        if (req[cur]) win = cur;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    owner_d   = owner_q;
    last_d    = last_q;
    valid_d   = valid_q;
    timeout_d = 1'b0;
    cnt_d     = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        gnt_d = '1;
        if (any_req && bus_idle) begin
          gnt_d   = ~(NUM_MASTERS'(1) << win);
          owner_d = win;
          valid_d = 1'b1;
          cnt_d   = '0;
          state_d = S_GRANTED;
        end
`ifdef ARB_PARK_EN
        // In IDLE the grant is only ever low while parked.
        else if (!gnt_q[PARK_MASTER] && !Frame) begin
          owner_d = OW'(PARK_MASTER);
          valid_d = 1'b1;
          state_d = S_BUSY;
        end else if (!any_req && bus_idle) begin
          gnt_d = ~(NUM_MASTERS'(1) << PARK_MASTER);
        end
`endif
      end
      S_GRANTED: begin
        if (!Frame) begin
          gnt_d   = '1;
          last_d  = owner_q;
          state_d = S_BUSY;
        end else if (REQ_n[owner_q]) begin
          gnt_d   = '1;
          valid_d = 1'b0;
          state_d = S_IDLE;
        end else if (cnt_q == 8'(GNT_TIMEOUT - 1)) begin
          // A timed-out master forfeits its round-robin turn.
          gnt_d     = '1;
          valid_d   = 1'b0;
          timeout_d = 1'b1;
          last_d    = owner_q;
          state_d   = S_IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_BUSY: begin
        if (bus_idle) begin
          valid_d = 1'b0;
          state_d = S_TURN;
        end
      end
      S_TURN: begin
        state_d = S_IDLE;
      end
      default: begin
        gnt_d   = '1;
        valid_d = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q   <= S_IDLE;
      gnt_q     <= '1;
      owner_q   <= '0;
      last_q    <= OW'(NUM_MASTERS - 1);
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      valid_q   <= valid_d;
      timeout_q <= timeout_d;
      cnt_q     <= cnt_d;
    end
  end

  assign GNT_n       = gnt_q;
  assign Owner       = owner_q;
  assign Owner_valid = valid_q;
  assign Timeout     = timeout_q;

endmodule

// File: tb/tb_pci_arbiter_n.sv
// tb/tb_pci_arbiter_n.sv - self-checking bench for pci_arbiter_n

module tb_pci_arbiter_n;

  localparam int N  = 3;
  localparam int TO = 16;
  localparam int PM = 2;

  logic         Clk = 1'b0;
  logic         Rst_n;
  logic [N-1:0] REQ_n;
  logic         Frame;
  logic         Irdy;
  logic         Mode;
  logic [N-1:0] GNT_n;
  logic [1:0]   Owner;
  logic         Owner_valid;
  logic         Timeout;

  int checks = 0;
  int errors = 0;

  pci_arbiter_n #(.NUM_MASTERS(N), .GNT_TIMEOUT(TO), .PARK_MASTER(PM)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .REQ_n(REQ_n), .Frame(Frame), .Irdy(Irdy),
    .Mode(Mode), .GNT_n(GNT_n), .Owner(Owner), .Owner_valid(Owner_valid),
    .Timeout(Timeout)
  );

  always #5 Clk = ~Clk;

  // Reference model: phase of the bus plus who holds the grant (-1 = none).
  localparam int P_ARB = 0, P_HOLD = 1, P_XFER = 2, P_TURN = 3;
  int m_phase, m_gnt, m_owner, m_valid, m_to, m_wait, m_last;

  task automatic model_reset();
    m_phase = P_ARB; m_gnt = -1; m_owner = 0; m_valid = 0;
    m_to = 0; m_wait = 0; m_last = N - 1;
  endtask

  // Fixed: lowest index. Round robin: smallest distance after last winner.
  function automatic int pick(logic [N-1:0] rq, logic md);
    int best = -1;
    int bestd = N + 1;
    for (int i = 0; i < N; i++) begin
      int d;
      d = md ? (i - m_last - 1 + 2 * N) % N : i;
      if (rq[i] && d < bestd) begin best = i; bestd = d; end
    end
    return best;
  endfunction

  function automatic logic [N-1:0] exp_gnt();
    logic [N-1:0] g = '1;
    if (m_gnt >= 0) g[m_gnt] = 1'b0;
    return g;
  endfunction

  task automatic model_step();
    logic [N-1:0] rq;
    bit idle;
    rq = ~REQ_n;
    idle = Frame && Irdy;
    m_to = 0;
    case (m_phase)
      P_ARB: begin
        if (rq != 0 && idle) begin
          m_gnt = pick(rq, Mode); m_owner = m_gnt; m_valid = 1;
          m_wait = 0; m_phase = P_HOLD;
        end
`ifdef ARB_PARK_EN
        else if (m_gnt == PM && !Frame) begin
          m_gnt = -1; m_owner = PM; m_valid = 1; m_phase = P_XFER;
        end else if (rq == 0 && idle) m_gnt = PM;
        else m_gnt = -1;
`else
        else m_gnt = -1;
`endif
      end
      P_HOLD: begin
        if (!Frame) begin
          m_gnt = -1; m_last = m_owner; m_phase = P_XFER;
        end else if (!rq[m_owner]) begin
          m_gnt = -1; m_valid = 0; m_phase = P_ARB;
        end else if (m_wait == TO - 1) begin
          m_gnt = -1; m_valid = 0; m_to = 1; m_last = m_owner; m_phase = P_ARB;
        end else m_wait++;
      end
      P_XFER: if (idle) begin m_valid = 0; m_phase = P_TURN; end
      default: m_phase = P_ARB;
    endcase
  endtask

  task automatic advance();
    model_step();
    @(posedge Clk);
    @(negedge Clk);
  endtask

  task automatic do_reset();
    Rst_n = 1'b0; REQ_n = '1; Frame = 1'b1; Irdy = 1'b1; Mode = 1'b0;
    repeat (2) @(negedge Clk);
    Rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    Rst_n = 1'b0; REQ_n = 3'b000; Frame = 1'b1; Irdy = 1'b1; Mode = 1'b0;
    repeat (3) @(negedge Clk);
    checks++; if (GNT_n !== 3'b111) begin errors++; $display("FAIL reset_gnt: got %b want 111", GNT_n); end
    checks++; if (Owner_valid !== 1'b0 || Owner !== 2'd0 || Timeout !== 1'b0) begin
      errors++; $display("FAIL reset_outs: valid=%b owner=%0d timeout=%b want 0,0,0", Owner_valid, Owner, Timeout);
    end
    Rst_n = 1'b1;
    model_reset();
    advance();
    checks++; if (GNT_n !== 3'b110 || GNT_n !== exp_gnt()) begin errors++; $display("FAIL reset_first_grant: got %b want 110", GNT_n); end
    checks++; if (Owner_valid !== 1'b1) begin errors++; $display("FAIL reset_first_valid: got %b want 1", Owner_valid); end
  endtask

  task automatic test_fixed_priority();
    do_reset();
    Mode = 1'b0; REQ_n = 3'b001;
    advance();
    checks++; if (GNT_n !== 3'b101) begin errors++; $display("FAIL fixed_grant1: got %b want 101", GNT_n); end
    Frame = 1'b0; REQ_n = 3'b011;
    for (int c = 0; c < 4; c++) begin
      advance();
      checks++; if (GNT_n !== 3'b111 || Owner_valid !== 1'b1) begin
        errors++; $display("FAIL fixed_busy: got %b valid %b want 111 valid 1", GNT_n, Owner_valid);
      end
    end
    Frame = 1'b1;
    advance();
    checks++; if (Owner_valid !== 1'b0 || GNT_n !== 3'b111) begin
      errors++; $display("FAIL fixed_turn: gnt %b valid %b want 111 valid 0", GNT_n, Owner_valid);
    end
    advance();
    checks++; if (GNT_n !== exp_gnt()) begin errors++; $display("FAIL fixed_idle: got %b want %b", GNT_n, exp_gnt()); end
    advance();
    checks++; if (GNT_n !== 3'b011 || Owner !== 2'd2) begin
      errors++; $display("FAIL fixed_grant2: gnt %b owner %0d want 011 owner 2", GNT_n, Owner);
    end
  endtask

  task automatic test_round_robin();
    int order[4] = '{0, 1, 2, 0};
    do_reset();
    Mode = 1'b1; REQ_n = 3'b000;
    for (int r = 0; r < 4; r++) begin
      advance();
      checks++; if (Owner !== 2'(order[r]) || Owner !== 2'(m_owner) || GNT_n !== exp_gnt()) begin
        errors++; $display("FAIL rr_owner%0d: owner %0d gnt %b want owner %0d gnt %b", r, Owner, GNT_n, order[r], exp_gnt());
      end
      Frame = 1'b0;
      advance(); advance();
      Frame = 1'b1;
      advance(); advance();
    end
  endtask

  task automatic test_timeout();
    int held = 0;
    int c = 0;
    do_reset();
    Mode = 1'b0; REQ_n = 3'b110;
    advance();
    while (GNT_n === 3'b110 && c < 40) begin held++; advance(); c++; end
    checks++; if (held != TO) begin errors++; $display("FAIL timeout_len: held %0d cycles want %0d", held, TO); end
    checks++; if (GNT_n !== 3'b111 || Timeout !== 1'b1 || Timeout !== 1'(m_to)) begin
      errors++; $display("FAIL timeout_pulse: gnt %b timeout %b want 111 timeout 1", GNT_n, Timeout);
    end
    REQ_n = 3'b100; Mode = 1'b1;
    advance();
    checks++; if (GNT_n !== 3'b101 || Timeout !== 1'b0) begin
      errors++; $display("FAIL timeout_next: gnt %b timeout %b want 101 timeout 0", GNT_n, Timeout);
    end
  endtask

  task automatic test_withdraw_and_async_reset();
    do_reset();
    Mode = 1'b0; REQ_n = 3'b011;
    advance();
    checks++; if (GNT_n !== 3'b011) begin errors++; $display("FAIL withdraw_grant: got %b want 011", GNT_n); end
    REQ_n = 3'b111;
    advance();
    checks++; if (GNT_n !== 3'b111 || Owner_valid !== 1'b0 || Owner !== 2'd2) begin
      errors++; $display("FAIL withdraw_drop: gnt %b valid %b owner %0d want 111 0 2", GNT_n, Owner_valid, Owner);
    end
    advance();
    checks++; if (GNT_n !== exp_gnt()) begin errors++; $display("FAIL withdraw_idle: got %b want %b", GNT_n, exp_gnt()); end
    REQ_n = 3'b110;
    advance();
    Frame = 1'b0;
    advance();
    checks++; if (Owner_valid !== 1'b1 || GNT_n !== 3'b111) begin
      errors++; $display("FAIL async_busy: valid %b gnt %b want 1 111", Owner_valid, GNT_n);
    end
    REQ_n = 3'b000;
    #2 Rst_n = 1'b0;
    #1;
    checks++; if (GNT_n !== 3'b111 || Owner_valid !== 1'b0) begin
      errors++; $display("FAIL async_reset: gnt %b valid %b want 111 0", GNT_n, Owner_valid);
    end
    @(negedge Clk);
    Frame = 1'b1; REQ_n = '1; Rst_n = 1'b1;
    model_reset();
  endtask

`ifdef ARB_PARK_EN
  task automatic test_park();
    do_reset();
    REQ_n = 3'b111;
    advance();
    checks++; if (GNT_n !== 3'b011 || Owner_valid !== 1'b0) begin
      errors++; $display("FAIL park_idle: gnt %b valid %b want 011 0", GNT_n, Owner_valid);
    end
    REQ_n = 3'b110;
    advance();
    checks++; if (GNT_n !== 3'b110) begin errors++; $display("FAIL park_replace: got %b want 110", GNT_n); end
  endtask
`endif

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 7) == 0) REQ_n = N'($urandom);
      if ($urandom_range(0, 15) == 0) Mode = 1'($urandom);
      Frame = ($urandom_range(0, 7) != 0);
      Irdy  = ($urandom_range(0, 5) != 0);
      advance();
      checks++; if (GNT_n !== exp_gnt()) begin errors++; $display("FAIL rand_gnt@%0d: got %b want %b", c, GNT_n, exp_gnt()); end
      checks++; if (Owner !== 2'(m_owner)) begin errors++; $display("FAIL rand_owner@%0d: got %0d want %0d", c, Owner, m_owner); end
      checks++; if (Owner_valid !== 1'(m_valid)) begin errors++; $display("FAIL rand_valid@%0d: got %b want %0d", c, Owner_valid, m_valid); end
      checks++; if (Timeout !== 1'(m_to)) begin errors++; $display("FAIL rand_timeout@%0d: got %b want %0d", c, Timeout, m_to); end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_fixed_priority();
    test_round_robin();
    test_timeout();
    test_withdraw_and_async_reset();
`ifdef ARB_PARK_EN
    test_park();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pci_arbiter_n.md
Name: pci_arbiter_n

Overview:
- Parametrised PCI central bus arbiter for NUM_MASTERS initiators. Successor to the fixed 3-master arbiter.
- Adds an asynchronous reset, runtime-selectable fixed-priority or round-robin mode, a grant-timeout recovery path and an owner-index output.
- Sits beside the Device instances on the shared Frame/Irdy bus. Drives one active-low GNT per master from the active-low REQ lines.

Parameters:
NUM_MASTERS, 3, number of initiators (2..8)
GNT_TIMEOUT, 16, cycles a granted master has to assert Frame before the grant is withdrawn (2..255)
PARK_MASTER, 0, master index that receives the parked grant (used only with ARB_PARK_EN)

Ports:
Clk  input  1  bus clock; all state changes on the rising edge
Rst_n  input  1  asynchronous active-low reset
REQ_n  input  NUM_MASTERS  per-master request, active low
Frame  input  1  PCI FRAME#, active low
Irdy  input  1  PCI IRDY#, active low
Mode  input  1  0 = fixed priority (index 0 highest), 1 = round robin
GNT_n  output  NUM_MASTERS  per-master grant, active low, registered, at most one low at a time
Owner  output  OW  index of the current or last granted master; OW = max(1, clog2(NUM_MASTERS))
Owner_valid  output  1  high while a requested grant or transaction is in progress
Timeout  output  1  one-cycle pulse when a grant is withdrawn by timeout

Behaviour:
- Reset (async assert, sync release):
  - GNT_n all 1, Owner = 0, Owner_valid = 0, Timeout = 0.
  - State IDLE, wait counter 0.
  - Round-robin pointer last = NUM_MASTERS-1, so master 0 wins first.
- Bus idle is defined as Frame=1 and Irdy=1.
- States: IDLE, GRANTED, BUSY, TURN.
- IDLE:
  - When any REQ_n bit is 0 and the bus is idle, pick a winner w on that edge.
  - Mode 0: winner is the lowest index requesting.
  - Mode 1: winner is the first requester searching last+1, last+2, … with wrap modulo NUM_MASTERS.
  - On that edge: GNT_n[w] goes 0, Owner = w, Owner_valid = 1, counter cleared, next state GRANTED.
  - Latency is one edge from the sampled request to the visible grant.
- GRANTED:
  - Frame sampled 0: next state BUSY, all GNT_n go 1, last = Owner (round-robin pointer commits only here).
  - Else REQ_n[Owner] sampled 1 (request withdrawn): GNT_n all 1, Owner_valid 0, next state IDLE, last unchanged.
  - Else counter reaches GNT_TIMEOUT-1: GNT_n all 1, Owner_valid 0, Timeout pulses 1 for one cycle, last = Owner (timed-out master loses its turn in Mode 1), next state IDLE.
  - Otherwise the counter increments and GNT_n is held.
  - Frame=0 and timeout on the same edge: Frame wins.
- BUSY:
  - Holds until the bus is idle, then next state TURN.
  - REQ_n changes are ignored.
- TURN:
  - One mandatory turnaround cycle, then IDLE.
  - Owner_valid drops to 0 on entry to TURN.
- Mode may change at any time; it is sampled only in IDLE at the arbitration edge.
- REQ_n bits outside the current owner never affect GRANTED, BUSY or TURN.
- Reset asserted mid-transaction forces all GNT_n to 1 immediately, without waiting for a clock.
- Owner holds its last value when Owner_valid is 0.

Optional Feature:
- Macro: ARB_PARK_EN.
- When defined:
  - In IDLE with no requests and the bus idle, GNT_n[PARK_MASTER] = 0 (parked) and Owner_valid stays 0.
  - If Frame is sampled 0 while parked, go directly to BUSY with Owner = PARK_MASTER and Owner_valid = 1.
  - Any request arriving while parked is arbitrated normally on the next edge. The parked grant is replaced with no idle gap.
  - The timeout counter does not run for a parked grant.
- When not defined: in IDLE with no requests, all GNT_n = 1.

Test Plan:
- Reset: NUM_MASTERS=3, hold Rst_n=0 with REQ_n=3'b000 and toggling Clk -> GNT_n=3'b111, Owner_valid=0. After release, Mode=0 -> GNT_n=3'b110 one edge later.
- Fixed priority: Mode=0, REQ_n=3'b001 -> GNT_n=3'b101 (master 1). Master 1 drives Frame=0 for 4 cycles then releases -> GNT_n=3'b111 during BUSY, one TURN cycle, then master 2 granted (GNT_n=3'b011).
- Round robin: Mode=1, REQ_n=3'b000 held, each winner runs a 2-cycle transaction -> grant order 0,1,2,0; Owner sequence 0,1,2,0.
- Timeout: GNT_TIMEOUT=16, REQ_n=3'b110, Frame held 1 -> GNT_n[0]=0 for exactly 16 cycles, then GNT_n=3'b111 and Timeout=1 for one cycle. Mode=1 with REQ_n=3'b100 -> master 1 is granted next.
- Withdrawn request and async reset: grant master 2, then REQ_n[2]=1 before Frame -> GNT_n=3'b111 next edge, state IDLE. Separately, assert Rst_n=0 mid-BUSY -> GNT_n=3'b111 and Owner_valid=0 without a clock edge.
- ARB_PARK_EN build, PARK_MASTER=2: REQ_n=3'b111 -> GNT_n=3'b011. Then REQ_n=3'b110 -> GNT_n=3'b110 on the next edge.
